// File: rtl/dna_syn_stream.sv
// dna_syn_stream: streaming position-weighted digit-sum syndrome engine for DNA codewords.
// Define DNA_SYN_CHECK_EN to add the syn_target input and the res_match output.
module dna_syn_stream #(
    parameter int N   = 24,
    parameter int K   = 4,
    parameter int MOD = 97,
    localparam int RSW = $clog2(4 * N * (N + 1) / 2 + 1),
    localparam int SW  = $clog2(MOD)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*K-1:0] in_digits,
    input  logic           in_last,
`ifdef DNA_SYN_CHECK_EN
    input  logic [SW-1:0]  syn_target,
    output logic           res_match,
`endif
    output logic           res_valid,
    input  logic           res_ready,
    output logic [RSW-1:0] res_raw,
    output logic [SW-1:0]  res_syn,
    output logic           res_err
);
    localparam int BEATS = N / K;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = RSW + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [AW-1:0] MOD_A     = AW'(MOD);
    localparam logic [SW:0]   MOD_S     = (SW + 1)'(MOD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Digit 00 carries value 4 so an all-zero word still has a non-trivial sum.
    function automatic logic [2:0] digit_val(input logic [1:0] d);
        digit_val = (d == 2'b00) ? 3'd4 : {1'b0, d};
    endfunction

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [RSW-1:0] raw_acc_q, raw_acc_d;
    logic [SW-1:0]  syn_acc_q, syn_acc_d;
    logic           res_valid_q, res_valid_d;
    logic [RSW-1:0] res_raw_q, res_raw_d;
    logic [SW-1:0]  res_syn_q, res_syn_d;
    logic           res_err_q, res_err_d;
`ifdef DNA_SYN_CHECK_EN
    logic           res_match_q, res_match_d;
`endif

    logic           accept_s;
    logic           at_last_beat_s;
    logic           terminal_s;
    logic           err_s;
    logic [AW-1:0]  weight_s;
    logic [AW-1:0]  partial_s;
    logic [AW-1:0]  partial_mod_s;
    logic [SW:0]    syn_sum_s;
    logic [SW-1:0]  syn_next_s;
    logic [RSW-1:0] raw_next_s;

    assign in_ready       = (state_q != S_DONE);
    assign accept_s       = in_valid && in_ready;
    assign at_last_beat_s = (beat_q == LAST_BEAT);
    assign terminal_s     = at_last_beat_s || in_last;
    // Short word (last too early) or missing last on the final beat.
    assign err_s          = at_last_beat_s ^ in_last;

    // Weighted sum of the current beat and the per-beat reduced syndrome update.
    always_comb begin
        partial_s = '0;
        weight_s  = '0;
        for (int j = 0; j < K; j++) begin
            weight_s  = AW'(beat_q) * AW'(K) + AW'(j) + AW'(1);
            partial_s = partial_s + AW'(digit_val(in_digits[2*j +: 2])) * weight_s;
        end
        partial_mod_s = partial_s % MOD_A;
        syn_sum_s     = {1'b0, syn_acc_q} + partial_mod_s[SW:0];
        if (syn_sum_s >= MOD_S) begin
            syn_next_s = SW'(syn_sum_s - MOD_S);
        end else begin
            syn_next_s = syn_sum_s[SW-1:0];
        end
        raw_next_s = raw_acc_q + partial_s[RSW-1:0];
    end

    // Next-state and result-load logic.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        raw_acc_d   = raw_acc_q;
        syn_acc_d   = syn_acc_q;
        res_valid_d = res_valid_q;
        res_raw_d   = res_raw_q;
        res_syn_d   = res_syn_q;
        res_err_d   = res_err_q;
`ifdef DNA_SYN_CHECK_EN
        res_match_d = res_match_q;
`endif
        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (accept_s) begin
                    raw_acc_d = raw_next_s;
                    syn_acc_d = syn_next_s;
                    if (terminal_s) begin
                        state_d     = S_DONE;
                        res_valid_d = 1'b1;
                        res_raw_d   = raw_next_s;
                        res_syn_d   = syn_next_s;
                        res_err_d   = err_s;
`ifdef DNA_SYN_CHECK_EN
                        res_match_d = (syn_next_s == syn_target) && !err_s;
`endif
                    end else begin
                        state_d = S_ACCUM;
                        beat_d  = beat_q + BW'(1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                    beat_d      = '0;
                    raw_acc_d   = '0;
                    syn_acc_d   = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            raw_acc_q   <= '0;
            syn_acc_q   <= '0;
            res_valid_q <= 1'b0;
            res_raw_q   <= '0;
            res_syn_q   <= '0;
            res_err_q   <= 1'b0;
`ifdef DNA_SYN_CHECK_EN
            res_match_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            raw_acc_q   <= raw_acc_d;
            syn_acc_q   <= syn_acc_d;
            res_valid_q <= res_valid_d;
            res_raw_q   <= res_raw_d;
            res_syn_q   <= res_syn_d;
            res_err_q   <= res_err_d;
`ifdef DNA_SYN_CHECK_EN
            res_match_q <= res_match_d;
`endif
        end
    end

    assign res_valid = res_valid_q;
    assign res_raw   = res_raw_q;
    assign res_syn   = res_syn_q;
    assign res_err   = res_err_q;
`ifdef DNA_SYN_CHECK_EN
    assign res_match = res_match_q;
`endif

endmodule
